// File: rtl/weight_pkg.sv
// weight_pkg: loader FSM state type and default widths shared with the neuron datapath
package weight_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam int NUM_WEIGHT = 5;
  localparam int ADDRESS_WIDTH = 3;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/weight_loader_if.sv
// weight_loader_if: weight stream (start/wvalid/wdata/wready), status (busy/loadDone) and read port (ren/radd/wout); master = host+MAC side, slave = loader
interface weight_loader_if import weight_pkg::*; #(
  parameter int dataWidth = DATA_WIDTH,
  parameter int addressWidth = ADDRESS_WIDTH
);
  logic start, wvalid, wready, busy, loadDone, ren;
  logic [dataWidth-1:0] wdata, wout;
  logic [addressWidth-1:0] radd;
  modport master(output start, wvalid, wdata, ren, radd, input wready, busy, loadDone, wout);
  modport slave(input start, wvalid, wdata, ren, radd, output wready, busy, loadDone, wout);
endinterface

// File: rtl/weight_ram.sv
// weight_ram: numWeight x dataWidth RAM; ports clk/rst, write we/wadd/wdata, registered read ren/radd/wout (out-of-range reads give 0, read-before-write)
module weight_ram import weight_pkg::*; #(
  parameter int numWeight = NUM_WEIGHT,
  parameter int addressWidth = ADDRESS_WIDTH,
  parameter int dataWidth = DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [addressWidth-1:0] wadd,
  input  logic [dataWidth-1:0] wdata,
  input  logic ren,
  input  logic [addressWidth-1:0] radd,
  output logic [dataWidth-1:0] wout
);
  localparam logic [addressWidth-1:0] last = addressWidth'(numWeight - 1);
  logic [dataWidth-1:0] mem [numWeight];
  always_ff @(posedge clk)
    if (we) mem[wadd] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) wout <= '0;
    else if (ren) wout <= radd <= last ? mem[radd] : '0;
endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams numWeight weights into weight_ram from address 0 after start; ports clk/rst plus bus (slave) carrying handshake, status and read port
module weight_loader import weight_pkg::*; #(
  parameter int numWeight = NUM_WEIGHT,
  parameter int addressWidth = ADDRESS_WIDTH,
  parameter int dataWidth = DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  weight_loader_if.slave bus
);
  localparam logic [addressWidth-1:0] last = addressWidth'(numWeight - 1);
  state_t state, state_n;
  logic [addressWidth-1:0] waddr, waddr_n;
  logic accept;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      waddr <= '0;
    end else begin
      state <= state_n;
      waddr <= waddr_n;
    end
  // outputs decode only the state register, so wready has no path from wvalid
  always_comb begin
    state_n = state;
    waddr_n = waddr;
    bus.wready = state == LOAD;
    bus.busy = state == LOAD;
    bus.loadDone = state == DONE;
    accept = state == LOAD && bus.wvalid;
    if (state != LOAD && bus.start) begin
      state_n = LOAD;
      waddr_n = '0;
    end else if (accept) begin
      state_n = waddr == last ? DONE : LOAD;
      waddr_n = waddr + 1'b1;
    end
  end
  weight_ram #(.numWeight(numWeight), .addressWidth(addressWidth), .dataWidth(dataWidth)) ram (
    .clk(clk), .rst(rst), .we(accept), .wadd(waddr), .wdata(bus.wdata),
    .ren(bus.ren), .radd(bus.radd), .wout(bus.wout)
  );
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: table-driven check of load, stall, reload collision, out-of-range/hold reads and async reset mid-load
module tb_weight_loader;
  typedef struct {
    logic start, wvalid;
    logic [7:0] wdata;
    logic ren;
    logic [2:0] radd;
    int st;
    logic [7:0] wout;
  } vec_t;
  localparam int I = 0, L = 1, D = 2;
  logic clk = 0, rst = 1;
  int errors = 0, checks = 0;
  vec_t tbl[$];
  weight_loader_if #(.dataWidth(8), .addressWidth(3)) bus();
  weight_loader dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic wv, logic [7:0] wd, logic r, logic [2:0] ra, int st, logic [7:0] wo);
    vec_t t;
    t.start = s; t.wvalid = wv; t.wdata = wd; t.ren = r; t.radd = ra; t.st = st; t.wout = wo;
    return t;
  endfunction

  task automatic chk(string n, int idx, logic [7:0] a, logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s step=%0d got=%h exp=%h", n, idx, a, e);
    end
  endtask

  task automatic outs(int idx, int st, logic [7:0] wo);
    chk("wready", idx, {7'd0, bus.wready}, {7'd0, st == L});
    chk("busy", idx, {7'd0, bus.busy}, {7'd0, st == L});
    chk("loadDone", idx, {7'd0, bus.loadDone}, {7'd0, st == D});
    chk("wout", idx, bus.wout, wo);
  endtask

  task automatic step(int idx, vec_t t);
    bus.start = t.start; bus.wvalid = t.wvalid; bus.wdata = t.wdata; bus.ren = t.ren; bus.radd = t.radd;
    @(posedge clk);
    #1;
    outs(idx, t.st, t.wout);
  endtask

  initial begin
    bus.start = 0; bus.wvalid = 0; bus.wdata = 0; bus.ren = 0; bus.radd = 0;
    repeat (2) @(posedge clk);
    #1;
    outs(-1, I, 8'h00);
    @(negedge clk);
    rst = 0;
    // idle with wvalid held and no start
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, I, 8'h00));
    tbl.push_back(mk(0, 1, 8'hFE, 0, 0, I, 8'h00));
    // full back-to-back load
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, L, 8'h00));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, L, 8'h00));
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, L, 8'h00));
    tbl.push_back(mk(0, 1, 8'h33, 0, 0, L, 8'h00));
    tbl.push_back(mk(0, 1, 8'h44, 0, 0, L, 8'h00));
    tbl.push_back(mk(0, 1, 8'h55, 0, 0, D, 8'h00));
    for (int a = 0; a < 5; a++) tbl.push_back(mk(0, 0, 0, 1, 3'(a), D, 8'(8'h11 * (a + 1))));
    // stalled load, then an extra word that must not be taken
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 0, 8'h99, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 0, 8'h98, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'h33, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 0, 8'h97, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'h44, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 0, 8'h96, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'h55, 0, 0, D, 8'h55));
    tbl.push_back(mk(0, 1, 8'h77, 0, 0, D, 8'h55));
    for (int a = 0; a < 5; a++) tbl.push_back(mk(0, 0, 0, 1, 3'(a), D, 8'(8'h11 * (a + 1))));
    // reload with a same-address read/write collision at address 2
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'hA0, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 0, L, 8'h55));
    tbl.push_back(mk(0, 1, 8'hA2, 1, 2, L, 8'h33));
    tbl.push_back(mk(0, 1, 8'hA3, 1, 2, L, 8'hA2));
    tbl.push_back(mk(0, 1, 8'hA4, 0, 2, D, 8'hA2));
    // out-of-range reads and hold with ren low
    tbl.push_back(mk(0, 0, 0, 1, 5, D, 8'h00));
    tbl.push_back(mk(0, 0, 0, 1, 1, D, 8'hA1));
    tbl.push_back(mk(0, 0, 0, 1, 6, D, 8'h00));
    tbl.push_back(mk(0, 0, 0, 1, 3, D, 8'hA3));
    tbl.push_back(mk(0, 0, 0, 1, 7, D, 8'h00));
    tbl.push_back(mk(0, 0, 0, 1, 4, D, 8'hA4));
    tbl.push_back(mk(0, 0, 0, 0, 0, D, 8'hA4));
    tbl.push_back(mk(0, 0, 0, 0, 5, D, 8'hA4));
    foreach (tbl[k]) step(k, tbl[k]);
    // reset mid-load after two words
    step(100, mk(1, 0, 8'h00, 0, 0, L, 8'hA4));
    step(101, mk(0, 1, 8'hB0, 0, 0, L, 8'hA4));
    step(102, mk(0, 1, 8'hB1, 0, 0, L, 8'hA4));
    rst = 1;
    #1;
    outs(103, I, 8'h00);
    @(negedge clk);
    rst = 0;
    step(104, mk(0, 1, 8'hEE, 0, 0, I, 8'h00));
    step(105, mk(0, 0, 8'h00, 1, 0, I, 8'hB0));
    step(106, mk(0, 0, 8'h00, 1, 2, I, 8'hA2));
    // reload; a start pulse during LOAD must not restart the address
    step(107, mk(1, 0, 8'h00, 0, 0, L, 8'hA2));
    step(108, mk(0, 1, 8'hC0, 0, 0, L, 8'hA2));
    step(109, mk(0, 1, 8'hC1, 0, 0, L, 8'hA2));
    step(110, mk(1, 1, 8'hC2, 0, 0, L, 8'hA2));
    step(111, mk(0, 1, 8'hC3, 0, 0, L, 8'hA2));
    step(112, mk(0, 1, 8'hC4, 0, 0, D, 8'hA2));
    for (int a = 0; a < 5; a++) step(113 + a, mk(0, 0, 0, 1, 3'(a), D, 8'(8'hC0 + a)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
